fifo_sync: RTL

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_sync_if.sv | 33 +++
 rtl/fifo_memory_sr.sv | 31 +++
 rtl/fifo_sync.sv | 92 +++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer/count width derivation (used by sync and async FIFOs).
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_if.sv
// Handshake/status bundle for fifo_sync; err_clr/ovf/udf exist only when SYNC_FIFO_ERR_EN is defined.
interface fifo_sync_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic                  w_en;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  r_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic                  err_clr;
  logic                  ovf;
  logic                  udf;

  modport master (output w_en, w_data, r_en, err_clr,
                  input  r_data, r_valid, full, empty, almost_full, almost_empty, count, ovf, udf);
  modport slave  (input  w_en, w_data, r_en, err_clr,
                  output r_data, r_valid, full, empty, almost_full, almost_empty, count, ovf, udf);
`else
  modport master (output w_en, w_data, r_en,
                  input  r_data, r_valid, full, empty, almost_full, almost_empty, count);
  modport slave  (input  w_en, w_data, r_en,
                  output r_data, r_valid, full, empty, almost_full, almost_empty, count);
`endif
endinterface

// File: rtl/fifo_memory_sr.sv
// Single-clock storage: one write port, one registered read port; the array itself is never reset.
module fifo_memory_sr #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register resets; it holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fifo_sync.sv
// Synchronous FIFO with registered flags/count; SYNC_FIFO_ERR_EN adds sticky ovf/udf with err_clr.
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AFULL_LVL  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fifo_sync_if.slave  bus
);
  localparam int            PW       = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
  localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_count;
  logic [PW-1:0] w_wr_nxt, w_rd_nxt, w_cnt_nxt;
  logic          r_full, r_empty, r_afull, r_aempty, r_valid;
  logic          w_wr_acc, w_rd_acc;

  // Gating on the registered flags gives read priority when full and write priority when empty.
  assign w_wr_acc  = bus.w_en & ~r_full;
  assign w_rd_acc  = bus.r_en & ~r_empty;
  assign w_wr_nxt  = w_wr_acc ? r_wr_ptr + PTR_ONE : r_wr_ptr;
  assign w_rd_nxt  = w_rd_acc ? r_rd_ptr + PTR_ONE : r_rd_ptr;
  assign w_cnt_nxt = w_wr_nxt - w_rd_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_cnt_nxt;
      r_full   <= (w_wr_nxt[PW-1] != w_rd_nxt[PW-1]) &&
                  (w_wr_nxt[PW-2:0] == w_rd_nxt[PW-2:0]);
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      r_afull  <= (w_cnt_nxt >= AFULL_C);
      r_aempty <= (w_cnt_nxt <= AEMPTY_C);
      r_valid  <= w_rd_acc;
    end
  end

  fifo_memory_sr #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
    .i_wdata (bus.w_data),
    .i_re    (w_rd_acc),
    .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
    .o_rdata (bus.r_data)
  );

  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_afull;
  assign bus.almost_empty = r_aempty;
  assign bus.r_valid      = r_valid;

`ifdef SYNC_FIFO_ERR_EN
  logic r_ovf, r_udf;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      r_ovf <= (bus.w_en & r_full)  | (r_ovf & ~bus.err_clr);
      r_udf <= (bus.r_en & r_empty) | (r_udf & ~bus.err_clr);
    end
  end

  assign bus.ovf = r_ovf;
  assign bus.udf = r_udf;
`endif
endmodule
